c5_decode: RTL and testbench
============================

Name: c5_decode

Overview:
Decode stage of the c5 RV32I pipeline, directly downstream of the fetch unit in c5_cpu. It captures each fetched instruction and its PC+4 in an IF/ID register and reads a 32x32 register file with a write-back port. It decodes control fields and immediates, and resolves branches and jumps early, driving the fetch redirect (pc_branch/pc_src). Decoded operands are registered into an ID/EX register for the execute stage.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.
NOP, 32'h00000013, instruction word loaded on bubble/flush (addi x0,x0,0).

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
I_instr  in  32  instruction from fetch
I_pc_plus_4  in  32  PC+4 of I_instr
I_stall  in  1  hazard stall: hold IF/ID, bubble into ID/EX
I_wb_we  in  1  register-file write enable
I_wb_rd  in  5  write-back destination
I_wb_data  in  32  write-back data
O_pc_branch  out  32  redirect target (combinational)
O_pc_src  out  1  take redirect this cycle (combinational)
O_rs1  out  5  rs1 address of the ID instruction, for hazard detection
O_rs2  out  5  rs2 address of the ID instruction, for hazard detection
O_valid_e  out  1  ID/EX holds a real instruction
O_pc_e  out  32  PC of the EX instruction
O_rs1_val_e  out  32  rs1 operand
O_rs2_val_e  out  32  rs2 operand
O_imm_e  out  32  sign-extended immediate
O_rd_e  out  5  destination register
O_funct3_e  out  3  funct3, passed through for ALU and load/store width
O_alu_op_e  out  4  {instr[30] (R-type or shift only), funct3}
O_alu_src_e  out  2  0=rs2, 1=imm, 2=pc+imm (AUIPC), 3=pc+4 (JAL/JALR)
O_mem_re_e  out  1  load
O_mem_we_e  out  1  store
O_reg_we_e  out  1  writes rd
O_illegal_e  out  1  unsupported opcode

Behaviour:
- Reset: IF/ID loads NOP with valid=0. All ID/EX outputs are 0. All 32 register-file entries clear to 0 over one reset cycle.
- IF/ID register, updated each clock edge:
  - I_stall=1: hold.
  - Else if O_pc_src=1: load NOP, valid=0 (squash the wrong-path fetch).
  - Else: load I_instr, I_pc_plus_4, valid=1.
- PC of the ID instruction = pc_plus_4 - 4.
- Register file:
  - Write on the clock edge when I_wb_we=1 and I_wb_rd!=0. Writes to x0 are ignored.
  - Read is combinational with write-first bypass: if I_wb_we and I_wb_rd==rs and rs!=0, the read returns I_wb_data.
  - x0 always reads 0.
  - Write-back is honoured during stall and during reset-free operation regardless of the valid bit.
- Immediates: I, S, B, U and J formats per RV32I, sign-extended from instr[31]. R-type gives imm=0.
- Early branch resolution, combinational, gated by IF/ID valid=1 and I_stall=0:
  - JAL: pc_src=1, target = pc + immJ.
  - JALR: pc_src=1, target = (rs1 + immI) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: compare the bypassed rs1/rs2 values (signed or unsigned per funct3). If true, pc_src=1 and target = pc + immB.
  - Otherwise pc_src=0 and O_pc_branch=0.
- Forwarding scope: there is no forwarding from EX/MEM inside this block. The external hazard unit stalls using O_rs1/O_rs2.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Control fields per opcode:
  - reg_we=1 for all except BRANCH and STORE; also forced to 0 when rd=0.
  - LUI is encoded as alu_src=1 with rs1 forced to x0, alu ADD.
  - Any other opcode: illegal_e=1, reg_we/mem_we/mem_re=0, valid_e=1.
- ID/EX register, updated each clock edge:
  - I_stall=1 or IF/ID valid=0: bubble (valid_e=0, all control outputs 0, data don't-care but driven 0).
  - Else: capture the decoded fields.
- Latency: fetch to ID/EX outputs is 2 clock edges; redirect is same-cycle combinational, costing 1 bubble.
- Simultaneous stall and branch: stall wins, pc_src=0, and the branch re-evaluates next cycle.
- Reset asserted mid-operation: the next edge applies the reset values; no partial state survives.

Test Plan:
- Reset 2 cycles, then hold I_rst=0 with the same instruction -> all ID/EX outputs 0, pc_src=0, x1..x31 read 0.
- I_instr=addi x5,x0,-3 (32'hFFD00293), pc_plus_4=0x104 -> two edges later: valid_e=1, imm_e=0xFFFFFFFD, rd_e=5, alu_src_e=1, reg_we_e=1, pc_e=0x100.
- Write x6=0x1234 via wb in the same cycle that ID holds add x7,x6,x6 -> rs1_val_e=rs2_val_e=0x1234 (bypass).
- x1=x2=7, beq x1,x2,+16 at pc 0x200 -> pc_src=1, pc_branch=0x210; the next IF/ID is squashed (valid_e=0 one cycle later). Set x2=8 -> pc_src=0.
- jal at pc 0x40 with I_stall=1 for 2 cycles -> pc_src=0 and valid_e=0 while stalled; when released, pc_src=1 for one cycle.
- wb write to x0 with 0xFFFFFFFF -> x0 reads 0. Opcode 7'b1110011 -> illegal_e=1, reg_we_e=0.

Source files
------------

// File: rtl/c5_decode_if.sv
// c5_decode_if: fetch, write-back and ID/EX bundle of the c5 decode stage
interface c5_decode_if;
   logic [31:0] I_instr;
   logic [31:0] I_pc_plus_4;
   logic        I_stall;
   logic        I_wb_we;
   logic [4:0]  I_wb_rd;
   logic [31:0] I_wb_data;
   logic [31:0] O_pc_branch;
   logic        O_pc_src;
   logic [4:0]  O_rs1;
   logic [4:0]  O_rs2;
   logic        O_valid_e;
   logic [31:0] O_pc_e;
   logic [31:0] O_rs1_val_e;
   logic [31:0] O_rs2_val_e;
   logic [31:0] O_imm_e;
   logic [4:0]  O_rd_e;
   logic [2:0]  O_funct3_e;
   logic [3:0]  O_alu_op_e;
   logic [1:0]  O_alu_src_e;
   logic        O_mem_re_e;
   logic        O_mem_we_e;
   logic        O_reg_we_e;
   logic        O_illegal_e;
   modport slave (
      input  I_instr, I_pc_plus_4, I_stall, I_wb_we, I_wb_rd, I_wb_data,
      output O_pc_branch, O_pc_src, O_rs1, O_rs2, O_valid_e, O_pc_e, O_rs1_val_e, O_rs2_val_e,
             O_imm_e, O_rd_e, O_funct3_e, O_alu_op_e, O_alu_src_e, O_mem_re_e, O_mem_we_e,
             O_reg_we_e, O_illegal_e
   );
   modport master (
      output I_instr, I_pc_plus_4, I_stall, I_wb_we, I_wb_rd, I_wb_data,
      input  O_pc_branch, O_pc_src, O_rs1, O_rs2, O_valid_e, O_pc_e, O_rs1_val_e, O_rs2_val_e,
             O_imm_e, O_rd_e, O_funct3_e, O_alu_op_e, O_alu_src_e, O_mem_re_e, O_mem_we_e,
             O_reg_we_e, O_illegal_e
   );
endinterface

// File: rtl/c5_decode.sv
// c5_decode: RV32I decode stage with IF/ID, register file, early branch resolution and ID/EX
module c5_decode #(
   parameter int          WIDTH = 32,
   parameter logic [31:0] NOP   = 32'h00000013
) (
   input logic      I_clk,
   input logic      I_rst,
   c5_decode_if.slave bus
);
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                          OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] rs1_val;
      logic [WIDTH-1:0] rs2_val;
      logic [WIDTH-1:0] imm;
      logic [4:0]       rd;
      logic [2:0]       funct3;
      logic [3:0]       alu_op;
      logic [1:0]       alu_src;
      logic             mem_re;
      logic             mem_we;
      logic             reg_we;
      logic             illegal;
   } idex_t;
   logic [WIDTH-1:0] instr_q, instr_d, pp4_q, pp4_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] rf_q [32];
   logic [WIDTH-1:0] rf_d [32];
   idex_t            ex_q, ex_d, dec;
   logic [6:0]       opcode;
   logic [2:0]       f3;
   logic [4:0]       rs1, rs2;
   logic [WIDTH-1:0] pc, rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j, target;
   logic             is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
   logic             br_true, take;
   assign opcode   = instr_q[6:0];
   assign f3       = instr_q[14:12];
   assign is_lui   = opcode == OP_LUI;
   assign is_auipc = opcode == OP_AUIPC;
   assign is_jal   = opcode == OP_JAL;
   assign is_jalr  = opcode == OP_JALR;
   assign is_br    = opcode == OP_BR;
   assign is_ld    = opcode == OP_LD;
   assign is_st    = opcode == OP_ST;
   assign is_opi   = opcode == OP_IMM;
   assign is_op    = opcode == OP_OP;
   assign rs1      = is_lui ? 5'd0 : instr_q[19:15];
   assign rs2      = instr_q[24:20];
   assign pc       = pp4_q - 32'd4;
   // write-first bypass so a same-cycle write-back is seen by decode and branch compare
   assign rs1_val  = rs1 == 5'd0 ? '0 : (bus.I_wb_we && bus.I_wb_rd == rs1) ? bus.I_wb_data : rf_q[rs1];
   assign rs2_val  = rs2 == 5'd0 ? '0 : (bus.I_wb_we && bus.I_wb_rd == rs2) ? bus.I_wb_data : rf_q[rs2];
   assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
   assign imm_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign imm_b    = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign imm_u    = {instr_q[31:12], 12'b0};
   assign imm_j    = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
   assign br_true  = f3[2:1] == 2'b00 ? (rs1_val == rs2_val) ^ f3[0] :
                     f3[2:1] == 2'b10 ? ($signed(rs1_val) < $signed(rs2_val)) ^ f3[0] :
                     f3[2:1] == 2'b11 ? (rs1_val < rs2_val) ^ f3[0] : 1'b0;
   assign take     = valid_q && !bus.I_stall && (is_jal || is_jalr || (is_br && br_true));
   assign target   = is_jalr ? (rs1_val + imm_i) & ~32'd1 : pc + (is_jal ? imm_j : imm_b);
   assign bus.O_pc_src    = take;
   assign bus.O_pc_branch = take ? target : '0;
   assign bus.O_rs1       = rs1;
   assign bus.O_rs2       = rs2;
   always_comb begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.pc      = pc;
      dec.rs1_val = rs1_val;
      dec.rs2_val = rs2_val;
      dec.rd      = instr_q[11:7];
      dec.funct3  = f3;
      dec.imm     = (is_ld || is_opi || is_jalr) ? imm_i : is_st ? imm_s : is_br ? imm_b :
                    (is_lui || is_auipc) ? imm_u : is_jal ? imm_j : '0;
      dec.alu_op  = is_lui ? 4'd0 : {instr_q[30] && (is_op || (is_opi && f3[1:0] == 2'b01)), f3};
      dec.alu_src = is_auipc ? 2'd2 : (is_jal || is_jalr) ? 2'd3 : (is_lui || is_ld || is_st || is_opi) ? 2'd1 : 2'd0;
      dec.mem_re  = is_ld;
      dec.mem_we  = is_st;
      dec.reg_we  = (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op) && instr_q[11:7] != 5'd0;
      dec.illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld || is_st || is_opi || is_op);
   end
   always_comb begin
      rf_d = rf_q;
      if (bus.I_wb_we && bus.I_wb_rd != 5'd0) rf_d[bus.I_wb_rd] = bus.I_wb_data;
      instr_d = bus.I_stall ? instr_q : take ? NOP : bus.I_instr;
      pp4_d   = bus.I_stall ? pp4_q : bus.I_pc_plus_4;
      valid_d = bus.I_stall ? valid_q : !take;
      ex_d    = (bus.I_stall || !valid_q) ? '0 : dec;
   end
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         instr_q <= NOP;
         pp4_q   <= '0;
         valid_q <= 1'b0;
         ex_q    <= '0;
         rf_q    <= '{default: '0};
      end else begin
         instr_q <= instr_d;
         pp4_q   <= pp4_d;
         valid_q <= valid_d;
         ex_q    <= ex_d;
         rf_q    <= rf_d;
      end
   end
   assign bus.O_valid_e   = ex_q.valid;
   assign bus.O_pc_e      = ex_q.pc;
   assign bus.O_rs1_val_e = ex_q.rs1_val;
   assign bus.O_rs2_val_e = ex_q.rs2_val;
   assign bus.O_imm_e     = ex_q.imm;
   assign bus.O_rd_e      = ex_q.rd;
   assign bus.O_funct3_e  = ex_q.funct3;
   assign bus.O_alu_op_e  = ex_q.alu_op;
   assign bus.O_alu_src_e = ex_q.alu_src;
   assign bus.O_mem_re_e  = ex_q.mem_re;
   assign bus.O_mem_we_e  = ex_q.mem_we;
   assign bus.O_reg_we_e  = ex_q.reg_we;
   assign bus.O_illegal_e = ex_q.illegal;
endmodule

// File: tb/tb_c5_decode.sv
// tb_c5_decode: scoreboard bench for c5_decode against an instruction-level reference model
module tb_c5_decode;
   localparam logic [31:0] NOP = 32'h00000013;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, r1v, r2v, imm;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [3:0]  aluop;
      logic [1:0]  alusrc;
      logic        mre, mwe, rwe, ill;
   } ex_t;
   typedef struct packed {
      logic        src;
      logic [31:0] tgt;
      logic [4:0]  rs1, rs2;
      ex_t         ex;
   } rec_t;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   c5_decode_if bus();
   c5_decode dut (.I_clk(clk), .I_rst(rst), .bus(bus));
   rec_t        sb[$];
   int          n_chk = 0, n_pass = 0;
   logic [31:0] m_rf [32];
   logic [31:0] m_instr, m_pp4;
   logic        m_valid;
   ex_t         m_ex;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask
   function automatic logic [31:0] sx(logic [31:0] v, int bits);
      return (v[bits-1]) ? v - (32'd1 << bits) : v;
   endfunction
   function automatic logic [31:0] imm_i(logic [31:0] i); return sx({20'd0, i[31:20]}, 12); endfunction
   function automatic logic [31:0] imm_s(logic [31:0] i); return sx({20'd0, i[31:25], i[11:7]}, 12); endfunction
   function automatic logic [31:0] imm_b(logic [31:0] i); return sx({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13); endfunction
   function automatic logic [31:0] imm_u(logic [31:0] i); return i & 32'hFFFFF000; endfunction
   function automatic logic [31:0] imm_j(logic [31:0] i); return sx({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); endfunction
   function automatic logic [31:0] rd_reg(logic [4:0] a);
      if (a == 0) return 0;
      if (bus.I_wb_we && bus.I_wb_rd == a) return bus.I_wb_data;
      return m_rf[a];
   endfunction
   function automatic ex_t decode(logic [31:0] i, logic [31:0] pc);
      ex_t e = '0;
      logic [2:0] f3 = i[14:12];
      e.valid = 1; e.pc = pc; e.rd = i[11:7]; e.f3 = f3;
      e.r1v = (i[6:0] == 7'b0110111) ? 0 : rd_reg(i[19:15]);
      e.r2v = rd_reg(i[24:20]);
      e.aluop = {1'b0, f3};
      case (i[6:0])
         7'b0110111: begin e.imm = imm_u(i); e.alusrc = 1; e.aluop = 0; e.rwe = 1; end
         7'b0010111: begin e.imm = imm_u(i); e.alusrc = 2; e.rwe = 1; end
         7'b1101111: begin e.imm = imm_j(i); e.alusrc = 3; e.rwe = 1; end
         7'b1100111: begin e.imm = imm_i(i); e.alusrc = 3; e.rwe = 1; end
         7'b1100011: e.imm = imm_b(i);
         7'b0000011: begin e.imm = imm_i(i); e.alusrc = 1; e.mre = 1; e.rwe = 1; end
         7'b0100011: begin e.imm = imm_s(i); e.alusrc = 1; e.mwe = 1; end
         7'b0010011: begin e.imm = imm_i(i); e.alusrc = 1; e.rwe = 1; if (f3 == 1 || f3 == 5) e.aluop[3] = i[30]; end
         7'b0110011: begin e.rwe = 1; e.aluop[3] = i[30]; end
         default: e.ill = 1;
      endcase
      if (e.rd == 0) e.rwe = 0;
      return e;
   endfunction
   task automatic resolve(output logic src, output logic [31:0] tgt);
      logic [31:0] pc = m_pp4 - 4, a = rd_reg(m_instr[19:15]), b = rd_reg(m_instr[24:20]), t = 0;
      logic tk = 0;
      case (m_instr[6:0])
         7'b1101111: begin tk = 1; t = pc + imm_j(m_instr); end
         7'b1100111: begin tk = 1; t = (a + imm_i(m_instr)) & 32'hFFFFFFFE; end
         7'b1100011: begin
            t = pc + imm_b(m_instr);
            case (m_instr[14:12])
               0: tk = a == b;
               1: tk = a != b;
               4: tk = $signed(a) < $signed(b);
               5: tk = $signed(a) >= $signed(b);
               6: tk = a < b;
               7: tk = a >= b;
               default: tk = 0;
            endcase
         end
         default: tk = 0;
      endcase
      if (!m_valid || bus.I_stall) tk = 0;
      src = tk;
      tgt = tk ? t : 0;
   endtask
   task automatic model_reset();
      m_instr = NOP; m_pp4 = 0; m_valid = 0; m_ex = '0;
      for (int k = 0; k < 32; k++) m_rf[k] = 0;
   endtask
   task automatic step(logic [31:0] instr, logic [31:0] pp4, logic stall, logic we, logic [4:0] wrd, logic [31:0] wd, logic r);
      rec_t rc;
      ex_t  nx;
      bus.I_instr = instr; bus.I_pc_plus_4 = pp4; bus.I_stall = stall;
      bus.I_wb_we = we; bus.I_wb_rd = wrd; bus.I_wb_data = wd; rst = r;
      resolve(rc.src, rc.tgt);
      rc.rs1 = (m_instr[6:0] == 7'b0110111) ? 5'd0 : m_instr[19:15];
      rc.rs2 = m_instr[24:20];
      rc.ex  = m_ex;
      sb.push_back(rc);
      nx = (stall || !m_valid) ? '0 : decode(m_instr, m_pp4 - 4);
      @(posedge clk);
      if (r) model_reset();
      else begin
         if (we && wrd != 0) m_rf[wrd] = wd;
         m_ex = nx;
         if (!stall) begin m_instr = rc.src ? NOP : instr; m_valid = !rc.src; m_pp4 = pp4; end
      end
      #1;
   endtask
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("pc_src", {31'd0, bus.O_pc_src}, {31'd0, r.src});
            chk("pc_branch", bus.O_pc_branch, r.tgt);
            chk("rs1", {27'd0, bus.O_rs1}, {27'd0, r.rs1});
            chk("rs2", {27'd0, bus.O_rs2}, {27'd0, r.rs2});
            chk("valid_e", {31'd0, bus.O_valid_e}, {31'd0, r.ex.valid});
            chk("pc_e", bus.O_pc_e, r.ex.pc);
            chk("rs1_val_e", bus.O_rs1_val_e, r.ex.r1v);
            chk("rs2_val_e", bus.O_rs2_val_e, r.ex.r2v);
            chk("imm_e", bus.O_imm_e, r.ex.imm);
            chk("rd_e", {27'd0, bus.O_rd_e}, {27'd0, r.ex.rd});
            chk("funct3_e", {29'd0, bus.O_funct3_e}, {29'd0, r.ex.f3});
            chk("alu_op_e", {28'd0, bus.O_alu_op_e}, {28'd0, r.ex.aluop});
            chk("alu_src_e", {30'd0, bus.O_alu_src_e}, {30'd0, r.ex.alusrc});
            chk("ctl_e", {28'd0, bus.O_mem_re_e, bus.O_mem_we_e, bus.O_reg_we_e, bus.O_illegal_e},
                {28'd0, r.ex.mre, r.ex.mwe, r.ex.rwe, r.ex.ill});
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   function automatic logic [31:0] rand_instr();
      logic [31:0] i = $urandom;
      logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
      i[6:0] = ops[$urandom_range(0, 9)];
      i[19:18] = 0; i[24:23] = 0; i[11:10] = 0;
      if (i[6:0] == 7'b0110011) begin i[31] = 0; i[29:25] = 0; end
      return i;
   endfunction
   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 4))
         0: return 0;
         1: return 1;
         2: return 7;
         3: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction
   initial begin
      bus.I_instr = NOP; bus.I_pc_plus_4 = 0; bus.I_stall = 0;
      bus.I_wb_we = 0; bus.I_wb_rd = 0; bus.I_wb_data = 0; rst = 1;
      @(posedge clk); #1;
      model_reset();
      step(NOP, 32'h4, 0, 0, 0, 0, 1);
      step(NOP, 32'h4, 0, 0, 0, 0, 0);
      step(32'h002081B3, 32'h8, 0, 0, 0, 0, 0);
      step(32'hFFD00293, 32'h104, 0, 0, 0, 0, 0);
      step(NOP, 32'h108, 0, 0, 0, 0, 0);
      step(32'h006303B3, 32'h10C, 0, 0, 0, 0, 0);
      step(NOP, 32'h110, 0, 1, 6, 32'h1234, 0);
      step(NOP, 32'h114, 0, 1, 1, 7, 0);
      step(NOP, 32'h118, 0, 1, 2, 7, 0);
      step(32'h00208863, 32'h204, 0, 0, 0, 0, 0);
      step(32'h00100093, 32'h208, 0, 0, 0, 0, 0);
      step(NOP, 32'h210, 0, 1, 2, 8, 0);
      step(32'h00208863, 32'h204, 0, 0, 0, 0, 0);
      step(NOP, 32'h208, 0, 0, 0, 0, 0);
      step(32'h008000EF, 32'h44, 0, 0, 0, 0, 0);
      step(NOP, 32'h48, 1, 0, 0, 0, 0);
      step(NOP, 32'h48, 1, 0, 0, 0, 0);
      step(NOP, 32'h48, 0, 0, 0, 0, 0);
      step(NOP, 32'h4C, 0, 1, 0, 32'hFFFFFFFF, 0);
      step(32'h00000033, 32'h50, 0, 0, 0, 0, 0);
      step(32'h00000073, 32'h54, 0, 0, 0, 0, 0);
      step(NOP, 32'h58, 0, 0, 0, 0, 0);
      step(NOP, 32'h5C, 0, 0, 0, 0, 0);
      for (int n = 0; n < 2000; n++)
         step(rand_instr(), {20'd0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom_range(0, 4) == 0,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), rand_data(), $urandom_range(0, 99) == 0);
      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
